vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
Owns the single-port synchronous frame-buffer RAM (320x240, 12-bit RGB) behind the 640x480 VGA timing generator. Each frame-buffer pixel is displayed as a 2x2 block of screen pixels. The block guarantees display reads on every even active pixel, and gives all remaining RAM cycles to two host ports (draw engine, solver readback) plus a built-in frame-clear engine. It also delays hsync/vsync/valid to match the RGB pipeline.

Parameters:
FB_W, 320, frame-buffer width in pixels
FB_H, 240, frame-buffer height in pixels
AW, 17, RAM address width (ceil log2 of FB_W*FB_H)
DW, 12, pixel width (4:4:4 RGB)

Ports:
pclk  in  1  pixel clock, 25 MHz
reset  in  1  asynchronous, active-low reset
h_cnt  in  10  timing generator column (0 outside active area)
v_cnt  in  10  timing generator row (0 outside active area)
valid_in  in  1  timing generator active-area flag
hsync_in  in  1  timing generator hsync
vsync_in  in  1  timing generator vsync
hsync  out  1  hsync_in delayed 2 cycles
vsync  out  1  vsync_in delayed 2 cycles
valid  out  1  valid_in delayed 2 cycles
rgb  out  12  display pixel, aligned with valid
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, 1-cycle latency after mem_en
hN_req  in  1  host N request, N=0,1; held until ack
hN_we  in  1  host N write(1)/read(0)
hN_addr  in  AW  host N address
hN_wdata  in  DW  host N write data
hN_ack  out  1  host N one-cycle completion pulse
hN_rdata  out  DW  host N read data, valid when hN_ack=1 for a read
clear_start  in  1  pulse: fill the whole buffer with clear_color
clear_color  in  12  fill value, sampled on clear_start
clear_busy  out  1  high while a clear is in progress

Behaviour:
- Reset (reset=0, async): hsync/vsync=1; valid=0; rgb=0; all acks=0; clear_busy=0; mem_en/mem_we=0; round-robin pointer=host0; clear FSM=IDLE.
- Display slot: valid_in=1 and h_cnt[0]=0. Issue a read at addr = (v_cnt>>1)*320 + (h_cnt>>1), computed as (y<<8)+(y<<6)+x. The address path uses no multiplier.
- Display data: register mem_rdata into a pixel register on the cycle after the slot. rgb = that register when the delayed valid=1, else 0. End-to-end latency is 2 cycles: hsync, vsync, valid and rgb all lag the inputs by exactly 2.
- Free cycle: any cycle that is not a display slot.
- Free-cycle priority: clear FSM > hosts. While clear_busy=1, hosts stall: no grants, requests stay pending.
- Host arbitration:
  - When both hosts are eligible, grant round-robin. The pointer moves to the other host after each grant.
  - When only one host is eligible, grant it; the pointer still flips past it.
  - A port is ineligible in the cycle its ack is high. This prevents a double grant of one transaction.
  - Grant issues the RAM access with that host's we/addr/wdata.
  - hN_ack pulses in the next cycle. For reads, hN_rdata = mem_rdata in the ack cycle and is held until the next read ack.
  - A host may drop req on ack, or present a new transaction.
- Clear FSM: IDLE -> FILL -> IDLE.
  - IDLE: clear_start=1 latches color, sets counter=0, goes to FILL, and sets clear_busy.
  - FILL: each free cycle writes color to counter and increments. After the write at FB_W*FB_H-1 (76799), return to IDLE and drop clear_busy the next cycle.
  - clear_start while busy is ignored.
- mem_addr is never >= FB_W*FB_H. Host addresses at or above that are acked without a RAM access; read data for them is 0.
- A reset mid-clear or mid-transaction aborts immediately. No ack is issued for the aborted transaction.
- Only one RAM access may be issued per cycle. mem_en=0 on idle cycles.

Decomposition:
- Shared package: FB_W, FB_H, AW, DW, the clear FSM state enum, and the display latency constant (2).
- Natural sub-module: fb_addr_gen, the combinational (y<<8)+(y<<6)+x address mapper, reused by draw-engine code.

Test Plan:
- Display map: preload addr 0=12'hF00 and addr 321=12'h0F0; run a frame. rgb=F00 at screen (0,0),(1,0),(0,1),(1,1); rgb=0F0 at (2,2),(3,3). Each appears 2 cycles after the matching h_cnt/v_cnt. rgb=0 in blanking.
- Host during active video: h0 write addr 5=12'hABC at an odd h_cnt. Granted that same cycle; h0_ack next cycle. A following h0 read of addr 5 returns ABC. No display slot is disturbed (display readback of the line is unchanged).
- Contention: h0 and h1 both request continuously in blanking. Grants alternate 0,1,0,1. Each ack is exactly one cycle and no transaction is granted twice.
- Clear: clear_start with color 12'h00F. clear_busy rises, all 76800 addresses hold 00F, and busy falls. A h1 request issued mid-clear is acked only after busy falls. A second clear_start mid-clear is ignored.
- Reset mid-clear: assert reset at counter about 1000. Immediately clear_busy=0, mem_en=0, acks=0, hsync=vsync=1. After release, a new clear completes normally.
- Out-of-range host address 76800: ack in 1 cycle, no mem_en, rdata=0.

Source files
------------

// File: rtl/vga_fb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter_pkg
// Purpose  : Shared geometry, widths, display latency and clear FSM states
//            for the VGA frame-buffer arbiter and its helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_fb_arbiter_pkg;

  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int AW       = 17;
  localparam int DW       = 12;
  localparam int FB_SIZE  = FB_W * FB_H;
  // Display path: slot read -> pixel register -> output
  localparam int DISP_LAT = 2;

  localparam logic [AW-1:0] FB_SIZE_A = AW'(FB_SIZE);
  localparam logic [AW-1:0] FB_LAST_A = AW'(FB_SIZE - 1);

  typedef enum logic [0:0] {
    CLR_IDLE = 1'b0,
    CLR_FILL = 1'b1
  } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter_if
// Purpose  : One host port of the frame-buffer arbiter (request/ack bus).
// Ports    : req/we/addr/wdata driven by the host (master),
//            ack/rdata driven by the arbiter (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface vga_fb_arbiter_if;
  import vga_fb_arbiter_pkg::*;

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, rdata);

endinterface
`default_nettype wire

// File: rtl/fb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fb_addr_gen
// Purpose  : Maps frame-buffer (x, y) to a linear RAM address y*320 + x,
//            built from two shifts and adds so no multiplier is inferred.
// Ports    : x (9b), y (9b) in; addr (AW) out
// Revision : 1.0 - initial release
// ============================================================================
module fb_addr_gen
  import vga_fb_arbiter_pkg::*;
(
  input  logic [8:0]    x,
  input  logic [8:0]    y,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] w_x;
  logic [AW-1:0] w_y;

  assign w_x  = {{(AW-9){1'b0}}, x};
  assign w_y  = {{(AW-9){1'b0}}, y};
  // 320 = 256 + 64
  assign addr = (w_y << 8) + (w_y << 6) + w_x;

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Owns the single-port frame-buffer RAM. Even active pixels are
//            reserved for display reads; all other cycles go to the frame
//            clear engine first, then to two round-robin host ports.
//            Sync/valid are delayed to line up with the RGB pipeline.
// Ports    : pclk, reset (async, active low)
//            h_cnt, v_cnt, valid_in, hsync_in, vsync_in  - timing generator
//            hsync, vsync, valid, rgb                     - display out
//            mem_en, mem_we, mem_addr, mem_wdata, mem_rdata - RAM
//            h0, h1                                       - host ports
//            clear_start, clear_color, clear_busy         - frame clear
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
(
  input  logic          pclk,
  input  logic          reset,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic          valid_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic          hsync,
  output logic          vsync,
  output logic          valid,
  output logic [DW-1:0] rgb,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  vga_fb_arbiter_if.slave h0,
  vga_fb_arbiter_if.slave h1,
  input  logic          clear_start,
  input  logic [DW-1:0] clear_color,
  output logic          clear_busy
);

  // ---------------- display slot ----------------
  logic          w_disp_slot;
  logic [AW-1:0] w_disp_addr;
  logic          w_unused_vlsb;

  // Slots are masked during reset so the RAM sees no access while aborted.
  assign w_disp_slot   = reset & valid_in & ~h_cnt[0];
  assign w_unused_vlsb = v_cnt[0];

  fb_addr_gen u_addr_gen (
    .x    (h_cnt[9:1]),
    .y    (v_cnt[9:1]),
    .addr (w_disp_addr)
  );

  logic [DISP_LAT-1:0] r_hs_pipe, r_vs_pipe, r_vld_pipe;
  logic                r_disp_d1;
  logic [DW-1:0]       r_pix;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_hs_pipe  <= '1;
      r_vs_pipe  <= '1;
      r_vld_pipe <= '0;
      r_disp_d1  <= 1'b0;
      r_pix      <= '0;
    end else begin
      r_hs_pipe  <= {r_hs_pipe[DISP_LAT-2:0],  hsync_in};
      r_vs_pipe  <= {r_vs_pipe[DISP_LAT-2:0],  vsync_in};
      r_vld_pipe <= {r_vld_pipe[DISP_LAT-2:0], valid_in};
      r_disp_d1  <= w_disp_slot;
      // Captured once per even pixel and held across the odd pixel.
      if (r_disp_d1) r_pix <= mem_rdata;
    end
  end

  assign hsync = r_hs_pipe[DISP_LAT-1];
  assign vsync = r_vs_pipe[DISP_LAT-1];
  assign valid = r_vld_pipe[DISP_LAT-1];
  assign rgb   = valid ? r_pix : '0;

  // ---------------- frame clear FSM ----------------
  clr_state_t    r_clr_state, w_clr_next;
  logic [AW-1:0] r_clr_cnt;
  logic [DW-1:0] r_clr_color;
  logic          w_clr_wr;

  assign clear_busy = (r_clr_state == CLR_FILL);

  always_comb begin
    w_clr_next = r_clr_state;
    w_clr_wr   = 1'b0;
    case (r_clr_state)
      CLR_IDLE: if (clear_start) w_clr_next = CLR_FILL;
      CLR_FILL: begin
        if (!w_disp_slot) begin
          w_clr_wr = 1'b1;
          if (r_clr_cnt == FB_LAST_A) w_clr_next = CLR_IDLE;
        end
      end
      default:  w_clr_next = CLR_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_clr_state <= CLR_IDLE;
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
    end else begin
      r_clr_state <= w_clr_next;
      if (r_clr_state == CLR_IDLE && clear_start) begin
        r_clr_cnt   <= '0;
        r_clr_color <= clear_color;
      end else if (w_clr_wr) begin
        r_clr_cnt   <= r_clr_cnt + 1'b1;
      end
    end
  end

  // ---------------- host arbitration ----------------
  logic [1:0]    w_req, w_we, w_ok, w_gnt, w_elig;
  logic [AW-1:0] w_haddr  [2];
  logic [DW-1:0] w_hwdata [2];
  logic [DW-1:0] w_hrdata [2];
  logic [1:0]    r_ack, r_rd, r_oor;
  logic [DW-1:0] r_rdata  [2];
  logic          r_rr_ptr;   // 0: host0 wins a tie, 1: host1 wins a tie
  logic          w_free;

  assign w_req       = {h1.req, h0.req};
  assign w_we        = {h1.we,  h0.we};
  assign w_haddr[0]  = h0.addr;
  assign w_haddr[1]  = h1.addr;
  assign w_hwdata[0] = h0.wdata;
  assign w_hwdata[1] = h1.wdata;
  assign w_free      = reset & ~w_disp_slot & ~clear_busy;
  // A port whose ack is high is presenting its next transaction (or the
  // same one it has not yet dropped), so it must sit out this cycle.
  assign w_elig      = w_req & ~r_ack;

  always_comb begin
    w_gnt = 2'b00;
    if (w_free) begin
      if (&w_elig)        w_gnt = r_rr_ptr ? 2'b10 : 2'b01;
      else if (w_elig[0]) w_gnt = 2'b01;
      else if (w_elig[1]) w_gnt = 2'b10;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset)        r_rr_ptr <= 1'b0;
    else if (w_gnt[0]) r_rr_ptr <= 1'b1;
    else if (w_gnt[1]) r_rr_ptr <= 1'b0;
  end

  for (genvar i = 0; i < 2; i++) begin : g_host
    assign w_ok[i]     = (w_haddr[i] < FB_SIZE_A);
    assign w_hrdata[i] = (r_ack[i] & r_rd[i]) ? (r_oor[i] ? '0 : mem_rdata)
                                              : r_rdata[i];
    always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
        r_ack[i]   <= 1'b0;
        r_rd[i]    <= 1'b0;
        r_oor[i]   <= 1'b0;
        r_rdata[i] <= '0;
      end else begin
        r_ack[i] <= w_gnt[i];
        r_rd[i]  <= w_gnt[i] & ~w_we[i];
        r_oor[i] <= w_gnt[i] & ~w_ok[i];
        if (r_ack[i] & r_rd[i]) r_rdata[i] <= w_hrdata[i];
      end
    end
  end

  assign h0.ack   = r_ack[0];
  assign h1.ack   = r_ack[1];
  assign h0.rdata = w_hrdata[0];
  assign h1.rdata = w_hrdata[1];

  // ---------------- RAM port mux (one access per cycle) ----------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_disp_slot) begin
      mem_en    = 1'b1;
      mem_addr  = w_disp_addr;
    end else if (w_clr_wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = r_clr_cnt;
      mem_wdata = r_clr_color;
    end else if (w_gnt[0] && w_ok[0]) begin
      mem_en    = 1'b1;
      mem_we    = w_we[0];
      mem_addr  = w_haddr[0];
      mem_wdata = w_hwdata[0];
    end else if (w_gnt[1] && w_ok[1]) begin
      mem_en    = 1'b1;
      mem_we    = w_we[1];
      mem_addr  = w_haddr[1];
      mem_wdata = w_hwdata[1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_arbiter
// Purpose  : Self-checking bench for vga_fb_arbiter with a behavioural
//            single-port RAM (1-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

  logic        pclk, reset;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid_in, hsync_in, vsync_in;
  logic        hsync, vsync, valid;
  logic [11:0] rgb;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [11:0] mem_wdata, mem_rdata;
  logic        clear_start, clear_busy;
  logic [11:0] clear_color;

  vga_fb_arbiter_if h0_if ();
  vga_fb_arbiter_if h1_if ();

  vga_fb_arbiter dut (
    .pclk(pclk), .reset(reset),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .valid_in(valid_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hsync(hsync), .vsync(vsync), .valid(valid), .rgb(rgb),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .h0(h0_if), .h1(h1_if),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Behavioural frame-buffer RAM
  logic [11:0] ram [0:76799];
  int          range_bad = 0;
  always @(posedge pclk) begin
    if (mem_en) begin
      if (mem_addr >= 17'd76800) range_bad <= range_bad + 1;
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_host(input int p, input logic req, input logic we,
                          input logic [16:0] addr, input logic [11:0] wd);
    if (p == 0) begin
      h0_if.req = req; h0_if.we = we; h0_if.addr = addr; h0_if.wdata = wd;
    end else begin
      h1_if.req = req; h1_if.we = we; h1_if.addr = addr; h1_if.wdata = wd;
    end
  endtask

  // Issue one host transaction and wait (bounded) for its ack.
  task automatic host_op(input int p, input logic we, input logic [16:0] addr,
                         input logic [11:0] wd, input int maxc,
                         output int cyc, output logic [11:0] rd);
    logic ack;
    ack = 1'b0;
    cyc = 0;
    set_host(p, 1'b1, we, addr, wd);
    while (!ack && cyc < maxc) begin
      @(negedge pclk); #1;
      cyc++;
      ack = (p == 0) ? h0_if.ack : h1_if.ack;
    end
    rd = (p == 0) ? h0_if.rdata : h1_if.rdata;
    set_host(p, 1'b0, 1'b0, 17'd0, 12'd0);
  endtask

  function automatic logic [11:0] pix(input logic [9:0] h, input logic [9:0] v);
    case ({v[1], h[1]})
      2'b00:   return 12'hF00;
      2'b11:   return 12'h0F0;
      default: return 12'h000;
    endcase
  endfunction

  typedef struct {
    logic        vin;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        en;
    logic [16:0] addr;
  } vec_t;

  typedef struct {
    logic        vin, hs, vs;
    logic [9:0]  h, v;
    logic [11:0] rgb;
  } frm_t;

  vec_t vecs [12];
  frm_t frm  [26];

  initial begin
    int          cyc, k0, k1, ack_cyc, fall_cyc, bad;
    logic [11:0] rd;
    bit          fell;

    vecs[0]  = '{1'b1, 10'd0,   10'd0,   1'b1, 17'd0};
    vecs[1]  = '{1'b1, 10'd2,   10'd0,   1'b1, 17'd1};
    vecs[2]  = '{1'b1, 10'd1,   10'd0,   1'b0, 17'd0};
    vecs[3]  = '{1'b1, 10'd0,   10'd2,   1'b1, 17'd320};
    vecs[4]  = '{1'b1, 10'd2,   10'd2,   1'b1, 17'd321};
    vecs[5]  = '{1'b1, 10'd638, 10'd479, 1'b1, 17'd76799};
    vecs[6]  = '{1'b1, 10'd639, 10'd479, 1'b0, 17'd0};
    vecs[7]  = '{1'b0, 10'd0,   10'd0,   1'b0, 17'd0};
    vecs[8]  = '{1'b1, 10'd100, 10'd51,  1'b1, 17'd8050};
    vecs[9]  = '{1'b1, 10'd638, 10'd0,   1'b1, 17'd319};
    vecs[10] = '{1'b1, 10'd0,   10'd479, 1'b1, 17'd76480};
    vecs[11] = '{1'b0, 10'd638, 10'd479, 1'b0, 17'd0};

    // ---- reset ----
    reset = 1'b0; h_cnt = '0; v_cnt = '0; valid_in = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; clear_start = 1'b0; clear_color = '0;
    set_host(0, 1'b0, 1'b0, 17'd0, 12'd0);
    set_host(1, 1'b0, 1'b0, 17'd0, 12'd0);
    repeat (3) @(negedge pclk);
    #1;
    chk("rst_hsync", hsync, 1); chk("rst_vsync", vsync, 1);
    chk("rst_valid", valid, 0); chk("rst_rgb", rgb, 0);
    chk("rst_ack0", h0_if.ack, 0); chk("rst_ack1", h1_if.ack, 0);
    chk("rst_busy", clear_busy, 0); chk("rst_en", mem_en, 0); chk("rst_we", mem_we, 0);
    reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;

    // ---- contention: pointer starts at host0, grants alternate ----
    @(negedge pclk); #1;
    k0 = 0; k1 = 0;
    set_host(0, 1'b1, 1'b1, 17'd100, 12'h100);
    set_host(1, 1'b1, 1'b1, 17'd200, 12'h200);
    for (int i = 1; i <= 8; i++) begin
      @(negedge pclk); #1;
      chk($sformatf("rr_ack0_%0d", i), h0_if.ack, (i % 2) == 1);
      chk($sformatf("rr_ack1_%0d", i), h1_if.ack, (i % 2) == 0);
      if (h0_if.ack) begin k0++; set_host(0, 1'b1, 1'b1, 17'(100 + k0), 12'(12'h100 + k0)); end
      if (h1_if.ack) begin k1++; set_host(1, 1'b1, 1'b1, 17'(200 + k1), 12'(12'h200 + k1)); end
    end
    set_host(0, 1'b0, 1'b0, 17'd0, 12'd0);
    set_host(1, 1'b0, 1'b0, 17'd0, 12'd0);
    for (int j = 0; j < 4; j++) begin
      host_op(1, 1'b0, 17'(100 + j), 12'd0, 20, cyc, rd);
      chk($sformatf("rr_rd0_%0d", j), rd, 12'(12'h100 + j));
      host_op(0, 1'b0, 17'(200 + j), 12'd0, 20, cyc, rd);
      chk($sformatf("rr_rd1_%0d", j), rd, 12'(12'h200 + j));
      chk($sformatf("rr_lat_%0d", j), cyc, 1);
    end

    // ---- table: display slot address mapping ----
    for (int i = 0; i < 12; i++) begin
      @(negedge pclk);
      valid_in = vecs[i].vin; h_cnt = vecs[i].h; v_cnt = vecs[i].v;
      #1;
      chk($sformatf("vec%0d_en", i), mem_en, vecs[i].en);
      if (vecs[i].en) begin
        chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
        chk($sformatf("vec%0d_we", i), mem_we, 0);
      end
    end
    @(negedge pclk);
    valid_in = 1'b0; h_cnt = '0; v_cnt = '0;

    // ---- display map: preload, then a 4x4 corner of the screen ----
    host_op(0, 1'b1, 17'd0,   12'hF00, 20, cyc, rd);
    host_op(0, 1'b1, 17'd1,   12'h000, 20, cyc, rd);
    host_op(1, 1'b1, 17'd320, 12'h000, 20, cyc, rd);
    host_op(1, 1'b1, 17'd321, 12'h0F0, 20, cyc, rd);
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 4; h++)
        frm[v*6 + h] = '{1'b1, 1'b1, 1'b1, 10'(h), 10'(v), pix(10'(h), 10'(v))};
      frm[v*6 + 4] = '{1'b0, 1'b0, (v != 3), 10'd0, 10'd0, 12'h000};
      frm[v*6 + 5] = '{1'b0, 1'b1, (v != 3), 10'd0, 10'd0, 12'h000};
    end
    frm[24] = '{1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 12'h000};
    frm[25] = frm[24];
    for (int k = 0; k < 26; k++) begin
      @(negedge pclk); #1;
      if (k >= 2) begin
        chk($sformatf("disp%0d_rgb", k - 2), rgb, frm[k-2].rgb);
        chk($sformatf("disp%0d_valid", k - 2), valid, frm[k-2].vin);
        chk($sformatf("disp%0d_hs", k - 2), hsync, frm[k-2].hs);
        chk($sformatf("disp%0d_vs", k - 2), vsync, frm[k-2].vs);
      end
      valid_in = frm[k].vin; hsync_in = frm[k].hs; vsync_in = frm[k].vs;
      h_cnt = frm[k].h; v_cnt = frm[k].v;
    end

    // ---- host access on odd active pixels ----
    @(negedge pclk); valid_in = 1'b1; v_cnt = 10'd4; h_cnt = 10'd0; #1;
    chk("act_h0_addr", mem_addr, 640); chk("act_h0_we", mem_we, 0);
    @(negedge pclk); h_cnt = 10'd1; set_host(0, 1'b1, 1'b1, 17'd5, 12'hABC); #1;
    chk("act_wr_en", mem_en, 1); chk("act_wr_we", mem_we, 1);
    chk("act_wr_addr", mem_addr, 5); chk("act_wr_data", mem_wdata, 12'hABC);
    @(negedge pclk); h_cnt = 10'd2; #1;
    chk("act_wr_ack", h0_if.ack, 1);
    chk("act_h2_addr", mem_addr, 641); chk("act_h2_we", mem_we, 0);
    set_host(0, 1'b1, 1'b0, 17'd5, 12'h000);
    @(negedge pclk); h_cnt = 10'd3; #1;
    chk("act_rd_en", mem_en, 1); chk("act_rd_we", mem_we, 0); chk("act_rd_addr", mem_addr, 5);
    @(negedge pclk); h_cnt = 10'd4; #1;
    chk("act_rd_ack", h0_if.ack, 1); chk("act_rd_data", h0_if.rdata, 12'hABC);
    chk("act_h4_addr", mem_addr, 642);
    set_host(0, 1'b0, 1'b0, 17'd0, 12'd0);
    @(negedge pclk); h_cnt = 10'd5; #1;
    chk("act_ack_pulse", h0_if.ack, 0);
    @(negedge pclk); valid_in = 1'b0; h_cnt = '0; v_cnt = '0;

    // ---- out-of-range host address ----
    @(negedge pclk); set_host(0, 1'b1, 1'b0, 17'd76800, 12'd0); #1;
    chk("oor_no_en", mem_en, 0);
    @(negedge pclk); #1;
    chk("oor_ack", h0_if.ack, 1); chk("oor_rdata", h0_if.rdata, 0);
    set_host(0, 1'b0, 1'b0, 17'd0, 12'd0);

    // ---- reset in the middle of a clear ----
    hsync_in = 1'b0; vsync_in = 1'b0;
    @(negedge pclk); clear_start = 1'b1; clear_color = 12'h0A5;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge pclk);
      clear_start = 1'b0;
    end
    #1;
    chk("mid_clr_addr", mem_addr, 999); chk("mid_clr_we", mem_we, 1);
    chk("mid_clr_data", mem_wdata, 12'h0A5); chk("mid_clr_busy", clear_busy, 1);
    set_host(0, 1'b1, 1'b1, 17'd7, 12'h555);
    #1; reset = 1'b0; #1;
    chk("abort_busy", clear_busy, 0); chk("abort_en", mem_en, 0);
    chk("abort_ack0", h0_if.ack, 0); chk("abort_ack1", h1_if.ack, 0);
    chk("abort_hsync", hsync, 1); chk("abort_vsync", vsync, 1);
    set_host(0, 1'b0, 1'b0, 17'd0, 12'd0);
    repeat (2) @(negedge pclk);
    reset = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;

    // ---- full clear, with a stalled host read and an ignored restart ----
    @(negedge pclk); clear_start = 1'b1; clear_color = 12'h00F;
    @(negedge pclk); clear_start = 1'b0; #1;
    chk("clr_busy_rise", clear_busy, 1);
    cyc = 1; fell = 1'b0; ack_cyc = 0; fall_cyc = 0;
    while (cyc < 80000 && ack_cyc == 0) begin
      @(negedge pclk);
      if (cyc == 100) begin clear_start = 1'b1; clear_color = 12'h123; end
      if (cyc == 101) clear_start = 1'b0;
      if (cyc == 200) set_host(1, 1'b1, 1'b0, 17'd10, 12'd0);
      #1;
      cyc++;
      if (!fell && !clear_busy) begin fell = 1'b1; fall_cyc = cyc; end
      if (h1_if.ack) begin ack_cyc = cyc; rd = h1_if.rdata; end
    end
    set_host(1, 1'b0, 1'b0, 17'd0, 12'd0);
    chk("clr_h1_acked", ack_cyc != 0, 1);
    chk("clr_fall_cycle", fall_cyc, 76801);
    chk("clr_ack_after_busy", ack_cyc, 76802);
    chk("clr_h1_rdata", rd, 12'h00F);
    bad = 0;
    for (int a = 0; a < 76800; a++) if (ram[a] !== 12'h00F) bad++;
    chk("clr_fill_words_bad", bad, 0);
    chk("addr_range", range_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
